// File: rtl/sub_nibble_seq.sv
// ---------------------------------------------------------------------------
// sub_nibble_seq
//   Nibble-serial subtractor: diff = a - b - bin over WIDTH bits, one 4-bit
//   slice per clock, LSB nibble first. The borrow travels between slices in
//   a register. Used for the Karatsuba middle-term correction.
//
//   Parameters
//     WIDTH  operand/result width, multiple of 4, >= 4 (N = WIDTH/4 steps)
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     start  request, sampled only while busy=0
//     a, b   minuend / subtrahend (latched on the start edge)
//     bin    borrow in, subtracted at bit 0
//     busy   operation in progress
//     done   one-cycle completion pulse
//     diff   result, held until the next completion
//     bout   final borrow out (1 = underflow), held with diff
//
//   Build option
//     SUB_CLAMP_EN  when defined, an underflowing result loads diff with 0
//                   (bout still reports 1). Timing is unchanged.
// ---------------------------------------------------------------------------
module sub_nibble_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic             borrow;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] work;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       s;
    logic [WIDTH-1:0] work_nxt;
    logic             last;

    // Select the active slice of the latched operands.
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // Subtraction as addition of the inverted subtrahend; carry-in is the
    // inverted borrow, carry-out is the inverted next borrow.
    assign s = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'b0000, ~borrow};

    // Working result with the current slice merged in. The completion edge
    // copies this (not the register) so the final nibble lands in diff.
    always_comb begin
        work_nxt = work;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) work_nxt[4*i +: 4] = s[3:0];
        end
    end

    assign last = (idx == IW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            borrow <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            work   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= bin;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    work   <= work_nxt;
                    borrow <= ~s[4];
                    if (last) begin
`ifdef SUB_CLAMP_EN
                        diff <= s[4] ? work_nxt : '0;
`else
                        diff <= work_nxt;
`endif
                        bout  <= ~s[4];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_nibble_seq.sv
// ---------------------------------------------------------------------------
// tb_sub_nibble_seq
//   Directed bench for sub_nibble_seq (WIDTH=16): a table of operand/result
//   records plus hand-written handshake and reset sequences.
// ---------------------------------------------------------------------------
module tb_sub_nibble_seq;

    localparam int W = 16;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;

    int checks = 0;
    int errors = 0;

    sub_nibble_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] d;
        logic        bo;
    } vec_t;

    vec_t vt[9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected diff after the optional clamp.
    function automatic logic [15:0] exp_d(input logic [15:0] d, input logic bo);
`ifdef SUB_CLAMP_EN
        return bo ? 16'h0000 : d;
`else
        return d;
`endif
    endfunction

    // Present operands with start for one edge, then scribble the inputs to
    // show only the latched copies matter. Returns at the negedge after edge 0.
    task automatic launch(input logic [15:0] ai, input logic [15:0] bi, input logic bini);
        @(negedge clk);
        a = ai; b = bi; bin = bini; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    endtask

    // Count cycles until done, checking busy stays high meanwhile (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            chk("busy_run", 32'(busy), 32'd1);
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        int lat;
        launch(v.a, v.b, v.bin);
        wait_done(lat);
        chk($sformatf("lat[%0d]", n), 32'(lat), 32'd4);
        chk($sformatf("busy_done[%0d]", n), 32'(busy), 32'd0);
        chk($sformatf("diff[%0d]", n), 32'(diff), 32'(exp_d(v.d, v.bo)));
        chk($sformatf("bout[%0d]", n), 32'(bout), 32'(v.bo));
        @(negedge clk);
        chk($sformatf("done_pulse[%0d]", n), 32'(done), 32'd0);
        chk($sformatf("diff_hold[%0d]", n), 32'(diff), 32'(exp_d(v.d, v.bo)));
    endtask

    initial begin
        int lat;

        vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
        vt[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
        vt[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vt[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1};
        vt[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vt[5] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFE, 1'b0};
        vt[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
        vt[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
        vt[8] = '{16'h0F0F, 16'hF0F0, 1'b0, 16'h1E1F, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        rst_n = 1'b1;

        foreach (vt[i]) run_vec(vt[i], i);

        // start while busy is ignored
        launch(16'h1234, 16'h0234, 1'b0);
        start = 1'b1; a = 16'hFFFF; b = 16'h0000; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", 32'(lat), 32'd3);
        chk("ign_diff", 32'(diff), 32'h1000);
        chk("ign_bout", 32'(bout), 32'd0);

        // start in the done cycle launches a new operation
        a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_drop", 32'(done), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_diff_hold", 32'(diff), 32'h1000);
        wait_done(lat);
        chk("b2b_lat", 32'(lat), 32'd4);
        chk("b2b_diff", 32'(diff), 32'h000F);
        chk("b2b_bout", 32'(bout), 32'd0);
        @(negedge clk);

        // Reset mid-operation, after edge 2
        launch(16'h1234, 16'h0234, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_bout", 32'(bout), 32'd0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_done", 32'(done), 32'd0);
        end
        run_vec(vt[8], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
